// File: rtl/irq_arbiter.sv
// Round-robin interrupt arbiter for the RV32i core: captures rising edges as pending bits,
// presents one enabled source to the trap logic and sequences request -> ack -> mret.
module irq_arbiter #(
    parameter int NUM_SRC    = 8,
    parameter int CAUSE_BASE = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               global_ie,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic               irq_req,
    output logic [31:0]        irq_cause,
    output logic               irq_busy,
    output logic [NUM_SRC-1:0] irq_pend
);

    localparam int IW = $clog2(NUM_SRC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] src_d;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] clr;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_found;
    logic [31:0]        arb_cause;

    assign rise = irq_src & ~src_d;
    assign elig = irq_pend & irq_mask;

    // Search starts just after the last serviced source so every source gets a turn.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!arb_found && elig[(int'(rr_ptr) + k) % NUM_SRC]) begin
                arb_found = 1'b1;
                arb_idx   = IW'((int'(rr_ptr) + k) % NUM_SRC);
            end
        end
    end

    assign arb_cause = {1'b1, 31'(CAUSE_BASE + int'(arb_idx))};

    always_comb begin
        clr = '0;
        if (state == REQ && irq_ack) begin
            clr[grant] = 1'b1;
        end
    end

    // Pending set has priority over the clear issued when the trap is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_d    <= '0;
            irq_pend <= '0;
        end else begin
            src_d    <= irq_src;
            irq_pend <= (irq_pend & ~clr) | rise;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= IW'(NUM_SRC - 1);
            irq_req   <= 1'b0;
            irq_cause <= '0;
            irq_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (global_ie && arb_found) begin
                        state     <= REQ;
                        grant     <= arb_idx;
                        irq_req   <= 1'b1;
                        irq_cause <= arb_cause;
                        irq_busy  <= 1'b1;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        state   <= SERVICE;
                        rr_ptr  <= grant;
                        irq_req <= 1'b0;
                    end else if (!global_ie || !irq_mask[grant]) begin
                        // Withdrawn request: the source stays pending for a later retry.
                        state    <= IDLE;
                        irq_req  <= 1'b0;
                        irq_busy <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (irq_done) begin
                        state    <= IDLE;
                        irq_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    irq_req  <= 1'b0;
                    irq_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
